// File: rtl/meancb.sv
// Luma-dependent Cb cluster centre for skin-tone detection.
// Two-stage pipeline: stage 1 picks the segment and distance, stage 2 divides and offsets.
module meancb #(
  parameter int unsigned K_L       = 125,
  parameter int unsigned K_H       = 188,
  parameter int unsigned Y_MIN     = 16,
  parameter int unsigned Y_MAX     = 235,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [7:0]           Y,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out
);

  localparam int unsigned SCALE  = 32'd1 << FRAC_BITS;
  localparam int unsigned DEN_LO = K_L - Y_MIN;
  localparam int unsigned DEN_HI = Y_MAX - K_H;
  localparam int unsigned BASE   = 108 * SCALE;
  localparam int unsigned SLOPE  = 10 * SCALE;
  // 10*S*d with an 8-bit d needs FRAC_BITS + 4 + 8 bits
  localparam int unsigned NUM_W  = FRAC_BITS + 12;
  localparam logic [7:0]  KL8    = 8'(K_L);
  localparam logic [7:0]  KH8    = 8'(K_H);

  typedef enum logic [1:0] {
    SEG_MID = 2'd0,
    SEG_LO  = 2'd1,
    SEG_HI  = 2'd2
  } seg_e;

  seg_e                 seg_q, seg_d;
  logic [7:0]           d_q, d_d;
  logic                 vld1_q, vld1_d;
  logic                 vld2_q, vld2_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;

  logic [NUM_W-1:0]     num_lo_c, num_hi_c;
  logic [NUM_W-1:0]     quo_lo_c, quo_hi_c;

  // Stage 1: segment select (knees belong to the outer segments) and distance from the knee
  always_comb begin
    seg_d  = seg_q;
    d_d    = d_q;
    vld1_d = in_valid;
    if (in_valid) begin
      seg_d = SEG_MID;
      d_d   = '0;
      if (Y <= KL8) begin
        seg_d = SEG_LO;
        d_d   = KL8 - Y;
      end else if (Y >= KH8) begin
        seg_d = SEG_HI;
        d_d   = Y - KH8;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q  <= SEG_MID;
      d_q    <= '0;
      vld1_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      d_q    <= d_d;
      vld1_q <= vld1_d;
    end
  end

  // Round-half-up quotient by each constant denominator; the segment picks one
  always_comb begin
    num_lo_c = NUM_W'(SLOPE) * NUM_W'(d_q) + NUM_W'(DEN_LO / 2);
    num_hi_c = NUM_W'(SLOPE) * NUM_W'(d_q) + NUM_W'(DEN_HI / 2);
    quo_lo_c = num_lo_c / NUM_W'(DEN_LO);
    quo_hi_c = num_hi_c / NUM_W'(DEN_HI);
  end

  // Stage 2: result register holds its value across invalid cycles
  always_comb begin
    out_d  = out_q;
    vld2_d = vld1_q;
    if (vld1_q) begin
      case (seg_q)
        SEG_LO:  out_d = OUT_WIDTH'(NUM_W'(BASE) + quo_lo_c);
        SEG_HI:  out_d = OUT_WIDTH'(NUM_W'(BASE) + quo_hi_c);
        default: out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      vld2_q <= vld2_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld2_q;

endmodule

// File: tb/tb_meancb.sv
// Directed bench for meancb: table of hand-computed vectors plus streaming,
// valid-gap and mid-stream reset sequences.
module tb_meancb;

  localparam int unsigned OUT_WIDTH = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [7:0]           Y;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [7:0]  y;
    logic [15:0] exp;
  } vec_t;

  meancb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .Y         (Y),
    .out_valid (out_valid),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer formula evaluated directly
  function automatic int model(input int y);
    int d;
    int den;
    if (y <= 125) begin
      d = 125 - y; den = 109;
    end else if (y >= 188) begin
      d = y - 188; den = 47;
    end else begin
      return 0;
    end
    return 108 * 256 + (10 * 256 * d + den / 2) / den;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One isolated sample: valid must stay low at latency 1 and rise at latency 2
  task automatic apply_vec(input logic [7:0] y, input logic [15:0] exp);
    @(negedge clk);
    Y        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check($sformatf("lat1_valid_y%0d", y), 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    Y        = 8'hA5;
    @(posedge clk); #1;
    check($sformatf("valid_y%0d", y), 32'(out_valid), 32'd1);
    check($sformatf("out_y%0d", y), 32'(out), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [13];
    logic [15:0] last_exp;
    logic        exp_v;

    vecs[0]  = '{8'd125, 16'd27648};
    vecs[1]  = '{8'd16,  16'd30208};
    vecs[2]  = '{8'd188, 16'd27648};
    vecs[3]  = '{8'd235, 16'd30208};
    vecs[4]  = '{8'd126, 16'd0};
    vecs[5]  = '{8'd150, 16'd0};
    vecs[6]  = '{8'd187, 16'd0};
    vecs[7]  = '{8'd0,   16'd30584};
    vecs[8]  = '{8'd255, 16'd31297};
    vecs[9]  = '{8'd124, 16'd27671};
    vecs[10] = '{8'd189, 16'd27702};
    vecs[11] = '{8'd100, 16'd28235};
    vecs[12] = '{8'd200, 16'd28302};

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    Y            = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 13; i++) apply_vec(vecs[i].y, vecs[i].exp);

    // Back-to-back stream of every luma code
    for (int c = 0; c < 258; c++) begin
      @(negedge clk);
      in_valid = (c < 256);
      Y        = 8'(c);
      @(posedge clk); #1;
      if (c == 0 || c == 257) begin
        check($sformatf("stream_edge_valid_c%0d", c), 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("stream_valid_y%0d", c - 1), 32'(out_valid), 32'd1);
        check($sformatf("stream_out_y%0d", c - 1), 32'(out), 32'(model(c - 1)));
      end
    end

    // Alternating valid: output follows two cycles later and holds in the gaps
    last_exp = 16'(model(255));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c < 8) && (c % 2 == 0);
      Y        = in_valid ? 8'(c * 30) : 8'd5;
      @(posedge clk); #1;
      exp_v = (c >= 1) && (c - 1 < 8) && ((c - 1) % 2 == 0);
      if (exp_v) last_exp = 16'(model((c - 1) * 30));
      check($sformatf("gap_valid_c%0d", c), 32'(out_valid), 32'(exp_v));
      check($sformatf("gap_out_c%0d", c), 32'(out), 32'(last_exp));
    end

    // Asynchronous reset while the pipeline is full
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      Y        = 8'(10 + c);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("no_stale_valid_c%0d", c), 32'(out_valid), 32'd0);
      check($sformatf("no_stale_out_c%0d", c), 32'(out), 32'd0);
    end
    apply_vec(8'd124, 16'd27671);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
